// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: ID-stage register-use info in,
// pipeline enables, flushes and forwarding selects out.
interface pipe_hazard_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [ADDR_W-1:0] id_rs;
   logic [ADDR_W-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [ADDR_W-1:0] id_dst;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              ex_branch_taken;
   logic              pc_write_en;
   logic              ifid_write_en;
   logic              ifid_flush;
   logic              idex_bubble;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_valid, id_rs, id_rt,
      output id_uses_rs, id_uses_rt,
      output id_dst, id_reg_write, id_mem_read,
      output ex_branch_taken,
      input  pc_write_en, ifid_write_en,
      input  ifid_flush, idex_bubble,
      input  fwd_a_sel, fwd_b_sel,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt,
      input  id_uses_rs, id_uses_rt,
      input  id_dst, id_reg_write, id_mem_read,
      input  ex_branch_taken,
      output pc_write_en, ifid_write_en,
      output ifid_flush, idex_bubble,
      output fwd_a_sel, fwd_b_sel,
      output stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/forwarding controller with
// EX/MEM/WB shadow registers and saturating debug counters.
module pipe_hazard_ctrl #(
   parameter int ADDR_W    = 5,
   parameter bit FWD_EN    = 1'b1,
   parameter bit WB_BYPASS = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave hz
);
   typedef logic [ADDR_W-1:0] reg_t;

   typedef struct packed {
      logic valid;
      reg_t rs;
      reg_t rt;
      logic uses_rs;
      logic uses_rt;
      reg_t dst;
      logic reg_write;
      logic mem_read;
   } shadow_t;

   localparam logic [CNT_W-1:0] CNT_ONE =
      {{(CNT_W-1){1'b0}}, 1'b1};

   shadow_t ex_q, mem_q, wb_q, ex_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic need_ex, need_mem, need_wb;
   logic stall_raw, stall_eff, flush, bubble;
   logic [1:0] fwd_a, fwd_b;
   logic unused_shadow;

   // r0 is hardwired zero and can never be a producer
   function automatic logic match(shadow_t s, reg_t r);
      return s.valid & s.reg_write &
             (s.dst != '0) & (s.dst == r);
   endfunction

   function automatic logic need(
      shadow_t s,
      logic    v,
      logic    urs,
      reg_t    rs,
      logic    urt,
      reg_t    rt
   );
      return v & ((urs & match(s, rs)) |
                  (urt & match(s, rt)));
   endfunction

   // hazard detection: stall/flush decision for the ID slot
   always_comb begin
      need_ex  = need(ex_q, hz.id_valid,
                      hz.id_uses_rs, hz.id_rs,
                      hz.id_uses_rt, hz.id_rt);
      need_mem = need(mem_q, hz.id_valid,
                      hz.id_uses_rs, hz.id_rs,
                      hz.id_uses_rt, hz.id_rt);
      need_wb  = need(wb_q, hz.id_valid,
                      hz.id_uses_rs, hz.id_rs,
                      hz.id_uses_rt, hz.id_rt);
      flush = hz.ex_branch_taken & ex_q.valid;
      if (FWD_EN) begin
         stall_raw = need_ex & ex_q.mem_read;
      end else begin
         stall_raw = need_ex | need_mem |
                     (need_wb & ~WB_BYPASS);
      end
      stall_eff = stall_raw & ~flush;
      bubble    = stall_eff | flush;
   end

   // operand forwarding for the instruction now in EX
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (FWD_EN) begin
         if (ex_q.uses_rs & match(mem_q, ex_q.rs)) begin
            fwd_a = 2'b01;
         end else if (match(wb_q, ex_q.rs)) begin
            fwd_a = 2'b10;
         end
         if (ex_q.uses_rt & match(mem_q, ex_q.rt)) begin
            fwd_b = 2'b01;
         end else if (match(wb_q, ex_q.rt)) begin
            fwd_b = 2'b10;
         end
      end
   end

   // next EX shadow: the ID instruction unless bubbled
   always_comb begin
      ex_d = '0;
      if (hz.id_valid & ~bubble) begin
         ex_d.valid     = 1'b1;
         ex_d.rs        = hz.id_rs;
         ex_d.rt        = hz.id_rt;
         ex_d.uses_rs   = hz.id_uses_rs;
         ex_d.uses_rt   = hz.id_uses_rt;
         ex_d.dst       = hz.id_dst;
         ex_d.reg_write = hz.id_reg_write;
         ex_d.mem_read  = hz.id_mem_read;
      end
   end

   // saturating debug counters, next-state
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_eff && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   // shadow pipeline advances every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   // debug counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.pc_write_en   = ~stall_eff;
   assign hz.ifid_write_en = ~stall_eff;
   assign hz.ifid_flush    = flush;
   assign hz.idex_bubble   = bubble;
   assign hz.fwd_a_sel     = fwd_a;
   assign hz.fwd_b_sel     = fwd_b;
   assign hz.stall_cnt     = stall_cnt_q;
   assign hz.flush_cnt     = flush_cnt_q;

   // MEM/WB keep full records; only some fields feed logic
   assign unused_shadow = ^{mem_q, wb_q};
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations driven
// in lockstep, checked against an instruction-level model.
module tb_pipe_hazard_ctrl;
   localparam int AW = 5;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          urs;
      logic          urt;
      logic [AW-1:0] dst;
      logic          rw;
      logic          mr;
   } ins_t;

   typedef struct packed {
      ins_t       id;
      logic       br;
      logic       pc;
      logic       bub;
      logic       fl;
      logic [1:0] fa;
      logic [1:0] fb;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic br;
   ins_t cur;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(16)) if_a ();
   pipe_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(16)) if_b ();
   pipe_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(2))  if_c ();

`define HOOK(I) \
   assign I.id_valid        = cur.valid; \
   assign I.id_rs           = cur.rs; \
   assign I.id_rt           = cur.rt; \
   assign I.id_uses_rs      = cur.urs; \
   assign I.id_uses_rt      = cur.urt; \
   assign I.id_dst          = cur.dst; \
   assign I.id_reg_write    = cur.rw; \
   assign I.id_mem_read     = cur.mr; \
   assign I.ex_branch_taken = br;

   `HOOK(if_a)
   `HOOK(if_b)
   `HOOK(if_c)
`undef HOOK

   pipe_hazard_ctrl #(
      .ADDR_W(AW), .FWD_EN(1'b1),
      .WB_BYPASS(1'b1), .CNT_W(16)
   ) u_a (.clk(clk), .rst(rst), .hz(if_a));

   pipe_hazard_ctrl #(
      .ADDR_W(AW), .FWD_EN(1'b0),
      .WB_BYPASS(1'b1), .CNT_W(16)
   ) u_b (.clk(clk), .rst(rst), .hz(if_b));

   pipe_hazard_ctrl #(
      .ADDR_W(AW), .FWD_EN(1'b0),
      .WB_BYPASS(1'b0), .CNT_W(2)
   ) u_c (.clk(clk), .rst(rst), .hz(if_c));

   // model configuration per instance
   bit fwd_m [3] = '{1'b1, 1'b0, 1'b0};
   bit byp_m [3] = '{1'b1, 1'b1, 1'b0};
   int cmax  [3] = '{65535, 65535, 3};

   // pipe[c][0]=EX, [1]=MEM, [2]=WB
   ins_t pipe [3][3];
   int   scnt [3];
   int   fcnt [3];

   int nchk = 0;
   int nerr = 0;

   vec_t tbl [$];

   task automatic chk(string nm,
                      logic [31:0] act,
                      logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
      end
   endtask

   function automatic ins_t mkI(int rs, int rt,
                                bit urs, bit urt,
                                int dst, bit rw, bit mr);
      ins_t i;
      i.valid = 1'b1;
      i.rs    = rs[AW-1:0];
      i.rt    = rt[AW-1:0];
      i.urs   = urs;
      i.urt   = urt;
      i.dst   = dst[AW-1:0];
      i.rw    = rw;
      i.mr    = mr;
      return i;
   endfunction

   function automatic bit prod(ins_t p, logic [AW-1:0] r);
      return p.valid && p.rw && p.dst != 0 && p.dst == r;
   endfunction

   // stall rule by producer distance (1=EX, 2=MEM, 3=WB)
   function automatic bit raw_stall(int c);
      logic [AW-1:0] src [2];
      bit usd [2];
      bit s = 1'b0;
      if (!cur.valid) return 1'b0;
      src[0] = cur.rs;
      src[1] = cur.rt;
      usd[0] = cur.urs;
      usd[1] = cur.urt;
      for (int k = 0; k < 2; k++) begin
         if (!usd[k]) continue;
         for (int d = 1; d <= 3; d++) begin
            if (!prod(pipe[c][d-1], src[k])) continue;
            if (fwd_m[c]) begin
               if (d == 1 && pipe[c][0].mr) s = 1'b1;
            end else if (d <= 2 || !byp_m[c]) begin
               s = 1'b1;
            end
         end
      end
      return s;
   endfunction

   function automatic int ex_src(int c,
                                 logic [AW-1:0] r,
                                 logic used);
      if (!fwd_m[c]) return 0;
      if (used && prod(pipe[c][1], r)) return 1;
      if (prod(pipe[c][2], r)) return 2;
      return 0;
   endfunction

   task automatic get_act(int c,
                          output logic pc, iw, fl, bub,
                          output logic [1:0] fa, fb,
                          output int sc, fc);
      case (c)
         0: begin
            pc = if_a.pc_write_en;  iw = if_a.ifid_write_en;
            fl = if_a.ifid_flush;   bub = if_a.idex_bubble;
            fa = if_a.fwd_a_sel;    fb = if_a.fwd_b_sel;
            sc = int'(if_a.stall_cnt);
            fc = int'(if_a.flush_cnt);
         end
         1: begin
            pc = if_b.pc_write_en;  iw = if_b.ifid_write_en;
            fl = if_b.ifid_flush;   bub = if_b.idex_bubble;
            fa = if_b.fwd_a_sel;    fb = if_b.fwd_b_sel;
            sc = int'(if_b.stall_cnt);
            fc = int'(if_b.flush_cnt);
         end
         default: begin
            pc = if_c.pc_write_en;  iw = if_c.ifid_write_en;
            fl = if_c.ifid_flush;   bub = if_c.idex_bubble;
            fa = if_c.fwd_a_sel;    fb = if_c.fwd_b_sel;
            sc = int'(if_c.stall_cnt);
            fc = int'(if_c.flush_cnt);
         end
      endcase
   endtask

   task automatic clr_model();
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < 3; s++) pipe[c][s] = '0;
         scnt[c] = 0;
         fcnt[c] = 0;
      end
   endtask

   // compare every instance to the model, then clock it
   task automatic model_step();
      logic pc, iw, fl, bub;
      logic [1:0] fa, fb;
      int sc, fc;
      bit e_fl, e_st;
      for (int c = 0; c < 3; c++) begin
         e_fl = br && pipe[c][0].valid;
         e_st = raw_stall(c) && !e_fl;
         get_act(c, pc, iw, fl, bub, fa, fb, sc, fc);
         chk($sformatf("cfg%0d pc_write_en", c), pc, !e_st);
         chk($sformatf("cfg%0d ifid_write_en", c), iw, !e_st);
         chk($sformatf("cfg%0d ifid_flush", c), fl, e_fl);
         chk($sformatf("cfg%0d idex_bubble", c), bub,
             e_st || e_fl);
         chk($sformatf("cfg%0d fwd_a_sel", c), fa,
             ex_src(c, pipe[c][0].rs, pipe[c][0].urs));
         chk($sformatf("cfg%0d fwd_b_sel", c), fb,
             ex_src(c, pipe[c][0].rt, pipe[c][0].urt));
         chk($sformatf("cfg%0d stall_cnt", c), sc, scnt[c]);
         chk($sformatf("cfg%0d flush_cnt", c), fc, fcnt[c]);
         if (rst) begin
            for (int s = 0; s < 3; s++) pipe[c][s] = '0;
            scnt[c] = 0;
            fcnt[c] = 0;
         end else begin
            pipe[c][2] = pipe[c][1];
            pipe[c][1] = pipe[c][0];
            pipe[c][0] = (cur.valid && !(e_st || e_fl)) ?
                         cur : '0;
            if (e_st && scnt[c] < cmax[c]) scnt[c]++;
            if (e_fl && fcnt[c] < cmax[c]) fcnt[c]++;
         end
      end
   endtask

   task automatic adv();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(ins_t id);
      cur = id;
      br  = 1'b0;
      #4;
   endtask

   task automatic addv(ins_t id, bit b, bit pc, bit bub,
                       bit fl, int fa, int fb);
      vec_t v;
      v.id  = id;
      v.br  = b;
      v.pc  = pc;
      v.bub = bub;
      v.fl  = fl;
      v.fa  = fa[1:0];
      v.fb  = fb[1:0];
      tbl.push_back(v);
   endtask

   initial begin
      ins_t nop, add3, sub4, add7, use7, add0, sub0;
      nop  = '0;
      add3 = mkI(1, 2, 1, 1, 3, 1, 0);
      sub4 = mkI(3, 5, 1, 1, 4, 1, 0);
      add7 = mkI(1, 2, 1, 1, 7, 1, 0);
      use7 = mkI(7, 1, 1, 1, 8, 1, 0);
      add0 = mkI(1, 2, 1, 1, 0, 1, 0);
      sub0 = mkI(0, 5, 1, 1, 4, 1, 0);

      // FWD_EN=1 vectors: ALU fwd, load-use, flush, r0
      addv(add3, 0, 1, 0, 0, 0, 0);
      addv(sub4, 0, 1, 0, 0, 0, 0);
      addv(mkI(3, 0, 1, 1, 6, 1, 0), 0, 1, 0, 0, 1, 0);
      addv(nop, 0, 1, 0, 0, 2, 0);
      addv(nop, 0, 1, 0, 0, 0, 0);
      addv(mkI(1, 0, 1, 0, 8, 1, 1), 0, 1, 0, 0, 0, 0);
      addv(mkI(8, 8, 1, 1, 9, 1, 0), 0, 0, 1, 0, 0, 0);
      addv(mkI(8, 8, 1, 1, 9, 1, 0), 0, 1, 0, 0, 0, 0);
      addv(nop, 0, 1, 0, 0, 2, 2);
      addv(mkI(1, 0, 1, 0, 10, 1, 1), 0, 1, 0, 0, 0, 0);
      addv(mkI(10, 2, 1, 1, 11, 1, 0), 1, 1, 1, 1, 0, 0);
      addv(nop, 1, 1, 0, 0, 0, 0);
      addv(add0, 0, 1, 0, 0, 0, 0);
      addv(sub0, 0, 1, 0, 0, 0, 0);
      addv(nop, 0, 1, 0, 0, 0, 0);
      addv(mkI(1, 0, 1, 0, 0, 1, 1), 0, 1, 0, 0, 0, 0);
      addv(mkI(0, 0, 1, 1, 12, 1, 0), 0, 1, 0, 0, 0, 0);
      addv(nop, 0, 1, 0, 0, 0, 0);

      rst = 1'b1;
      cur = '0;
      br  = 1'b0;
      clr_model();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      #4;
      chk("reset pc_write_en", if_a.pc_write_en, 1);
      chk("reset ifid_write_en", if_b.ifid_write_en, 1);
      chk("reset ifid_flush", if_a.ifid_flush, 0);
      chk("reset idex_bubble", if_c.idex_bubble, 0);
      chk("reset fwd_a_sel", if_a.fwd_a_sel, 0);
      chk("reset fwd_b_sel", if_a.fwd_b_sel, 0);
      chk("reset stall_cnt", if_a.stall_cnt, 0);
      adv();

      foreach (tbl[i]) begin
         cur = tbl[i].id;
         br  = tbl[i].br;
         #4;
         chk($sformatf("vec%0d pc_write_en", i),
             if_a.pc_write_en, tbl[i].pc);
         chk($sformatf("vec%0d ifid_write_en", i),
             if_a.ifid_write_en, tbl[i].pc);
         chk($sformatf("vec%0d idex_bubble", i),
             if_a.idex_bubble, tbl[i].bub);
         chk($sformatf("vec%0d ifid_flush", i),
             if_a.ifid_flush, tbl[i].fl);
         chk($sformatf("vec%0d fwd_a_sel", i),
             if_a.fwd_a_sel, tbl[i].fa);
         chk($sformatf("vec%0d fwd_b_sel", i),
             if_a.fwd_b_sel, tbl[i].fb);
         adv();
      end
      chk("fwd stall_cnt total", if_a.stall_cnt, 1);
      chk("fwd flush_cnt total", if_a.flush_cnt, 1);

      // interlock-only: RAW gap of 2 (B) or 3 (C) cycles
      rst = 1'b1;
      put(nop);
      adv();
      rst = 1'b0;
      put(add3);
      chk("ilk t0 pc", if_b.pc_write_en, 1);
      adv();
      put(sub4);
      chk("ilk t1 pc", if_b.pc_write_en, 0);
      chk("ilk t1 bubble", if_b.idex_bubble, 1);
      chk("ilk t1 nobyp pc", if_c.pc_write_en, 0);
      adv();
      put(sub4);
      chk("ilk t2 pc", if_b.pc_write_en, 0);
      chk("ilk t2 nobyp pc", if_c.pc_write_en, 0);
      adv();
      put(sub4);
      chk("ilk t3 pc", if_b.pc_write_en, 1);
      chk("ilk t3 bubble", if_b.idex_bubble, 0);
      chk("ilk t3 nobyp pc", if_c.pc_write_en, 0);
      adv();
      put(nop);
      chk("ilk ex fwd_a", if_b.fwd_a_sel, 0);
      chk("ilk ex fwd_b", if_b.fwd_b_sel, 0);
      chk("ilk stall_cnt", if_b.stall_cnt, 2);
      chk("nobyp stall_cnt", if_c.stall_cnt, 3);
      adv();

      // more stalls: C saturates at 3
      put(add7);
      adv();
      for (int k = 0; k < 3; k++) begin
         put(use7);
         adv();
      end
      put(nop);
      chk("ilk stall_cnt 2", if_b.stall_cnt, 4);
      chk("sat stall_cnt", if_c.stall_cnt, 3);
      adv();

      // r0 destination never interlocks
      put(add0);
      adv();
      put(sub0);
      chk("r0 ilk pc", if_b.pc_write_en, 1);
      chk("r0 nobyp pc", if_c.pc_write_en, 1);
      adv();

      // reset in the middle of a stall
      put(add3);
      adv();
      put(sub4);
      chk("pre-rst stall pc", if_b.pc_write_en, 0);
      rst = 1'b1;
      adv();
      rst = 1'b0;
      put(nop);
      chk("post-rst ex valid", u_b.ex_q.valid, 0);
      chk("post-rst mem valid", u_b.mem_q.valid, 0);
      chk("post-rst wb valid", u_b.wb_q.valid, 0);
      chk("post-rst pc", if_b.pc_write_en, 1);
      chk("post-rst stall_cnt", if_b.stall_cnt, 0);
      chk("post-rst flush_cnt", if_b.flush_cnt, 0);
      adv();

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         ins_t r;
         rst     = ($urandom_range(0, 63) == 0);
         r.valid = ($urandom_range(0, 3) != 0);
         r.rs    = AW'($urandom_range(0, 7));
         r.rt    = AW'($urandom_range(0, 7));
         r.urs   = $urandom_range(0, 1);
         r.urt   = $urandom_range(0, 1);
         r.dst   = AW'($urandom_range(0, 7));
         r.rw    = ($urandom_range(0, 3) != 0);
         r.mr    = r.rw & ($urandom_range(0, 2) == 0);
         cur     = r;
         br      = ($urandom_range(0, 3) == 0);
         #4;
         adv();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               nchk, nerr);
      $finish;
   end
endmodule
